iob_2p_ram_rd_stream: RTL and testbench

Reader engine for the read port of a dual-port block RAM whose read data is registered (1-cycle latency, data valid the cycle after r_en).
On a start command it reads len consecutive words from base_addr, wrapping modulo 2**ADDR_W, and presents them as a valid/ready stream with a last flag.
It absorbs the RAM read latency under backpressure with a 2-entry output buffer.
It sits between a dual-port RAM filled by a writer engine and a streaming consumer (DMA or accelerator input).

---
 rtl/iob_2p_ram_rd_stream_pkg.sv | 16 +
 rtl/iob_2p_ram_rd_stream_if.sv | 14 +
 rtl/iob_stream_buf2.sv | 47 ++++
 rtl/iob_2p_ram_rd_stream.sv | 125 ++++++++++++
 tb/tb_iob_2p_ram_rd_stream.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_2p_ram_rd_stream_pkg.sv
// Shared definitions for the RAM read-stream engine.
//   state_t   : transfer FSM encoding (idle / issuing reads / draining buffer)
//   BUF_DEPTH : entries in the output skid buffer that absorbs RAM read latency
//   OCC_W     : width of the buffer occupancy count (0..BUF_DEPTH)
package iob_2p_ram_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCC_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/iob_2p_ram_rd_stream_if.sv
// Valid/ready stream carrying RAM words to a consumer.
//   m_valid : word available      m_ready : consumer accepts
//   m_data  : word                m_last  : final word of the transfer
interface iob_2p_ram_rd_stream_if #(
    parameter int unsigned DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/iob_stream_buf2.sv
// Two-entry synchronous FIFO holding RAM words (with their last flag) until
// the consumer takes them.
//   clk, rst : clock, async active-high reset
//   push/din : write an entry      pop : drop the head entry
//   dout     : head entry          occ : number of valid entries
module iob_stream_buf2
    import iob_2p_ram_rd_stream_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [OCC_W-1:0] occ
);

    logic [W-1:0] mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; push and pop together leave occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/iob_2p_ram_rd_stream.sv
// Reads len consecutive words (wrapping) from a registered-output RAM read
// port and streams them out with a last flag.
//   clk, rst          : clock, async active-high reset
//   start/base_addr/len: transfer command, taken only while idle
//   busy, done        : transfer in progress / one-cycle completion pulse
//   ram_r_en/addr/data: RAM read port, data valid the cycle after ram_r_en
//   m                 : output stream (valid/ready/data/last)
module iob_2p_ram_rd_stream
    import iob_2p_ram_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        len,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_r_en,
    output logic [ADDR_W-1:0]      ram_r_addr,
    input  logic [DATA_W-1:0]      ram_r_data,
    iob_2p_ram_rd_stream_if.master m
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   rd_left_q, rd_left_d;
    logic [CNT_W-1:0]   wr_left_q, wr_left_d;
    logic               done_q, done_d;
    logic               inflight_q;
    logic               inflight_last_q;

    logic               pop;
    logic               credit_ok;
    logic [OCC_W-1:0]   occ;
    logic [DATA_W:0]    head;

    assign pop = m.m_valid & m.m_ready;

    // Issue only if the word landing next cycle is guaranteed a buffer slot.
    assign credit_ok = (3'({1'b0, occ}) + 3'(inflight_q)) < (3'd2 + 3'(pop));

    // State, address and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rd_left_q       <= '0;
            wr_left_q       <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rd_left_q       <= rd_left_d;
            wr_left_q       <= wr_left_d;
            done_q          <= done_d;
            inflight_q      <= ram_r_en;
            inflight_last_q <= ram_r_en && (rd_left_q == CNT_W'(1));
        end
    end

    // Next-state, read issue and completion.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_left_d = rd_left_q;
        wr_left_d = pop ? (wr_left_q - CNT_W'(1)) : wr_left_q;
        done_d    = 1'b0;
        ram_r_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d    = base_addr;
                        rd_left_d = len;
                        wr_left_d = len;
                        state_d   = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                ram_r_en = (rd_left_q != '0) && credit_ok;
                if (ram_r_en) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - CNT_W'(1);
                    if (rd_left_q == CNT_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Final word leaves the buffer: finish on this edge.
                if (pop && (wr_left_q == CNT_W'(1))) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    iob_stream_buf2 #(.W(DATA_W + 1)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .din  ({inflight_last_q, ram_r_data}),
        .pop  (pop),
        .dout (head),
        .occ  (occ)
    );

    assign ram_r_addr = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign m.m_valid  = (occ != '0);
    assign m.m_data   = head[DATA_W-1:0];
    assign m.m_last   = m.m_valid & head[DATA_W];

endmodule

// File: tb/tb_iob_2p_ram_rd_stream.sv
// Directed bench for iob_2p_ram_rd_stream (ADDR_W=4, mem[i]=0x100+i).
module tb_iob_2p_ram_rd_stream;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, ram_r_en;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_r_data = '0;
    logic [DATA_W-1:0] mem [DEPTH];

    iob_2p_ram_rd_stream_if #(.DATA_W(DATA_W)) m_if ();

    iob_2p_ram_rd_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_r_en   (ram_r_en),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data),
        .m          (m_if.master)
    );

    always #5 clk = ~clk;

    // Registered-output RAM read port.
    always @(posedge clk) if (ram_r_en) ram_r_data <= mem[ram_r_addr];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = fixed 1,0,0,1,0,1, 2 = random.
    int         rdy_mode = 0;
    int         rdy_idx  = 0;
    logic [5:0] rdy_pat  = 6'b101001;
    initial m_if.m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_if.m_ready = 1'b1;
            1: begin
                m_if.m_ready = rdy_pat[rdy_idx % 6];
                rdy_idx++;
            end
            default: m_if.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle observer: logs reads/handshakes and checks buffer-level rules.
    logic [31:0]       got_q [$];
    logic              last_q [$];
    int                addr_q [$];
    int                first_en = -1, first_v = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
    int                occ_m = 0, infl_m = 0;
    logic              pop_s, stall_prev = 1'b0, prev_last;
    logic [DATA_W-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            occ_m = 0; infl_m = 0; stall_prev = 1'b0;
        end else begin
            pop_s = m_if.m_valid & m_if.m_ready;
            check("m_valid_vs_occ", 32'(m_if.m_valid), 32'(occ_m > 0));
            if (ram_r_en) begin
                addr_q.push_back(int'(ram_r_addr));
                if (first_en < 0) first_en = cyc;
                check("credit", 32'((occ_m + infl_m - int'(pop_s)) < 2), 32'd1);
            end
            if (m_if.m_valid && first_v < 0) first_v = cyc;
            if (stall_prev) begin
                check("hold_data", m_if.m_data, prev_data);
                check("hold_last", 32'(m_if.m_last), 32'(prev_last));
            end
            if (pop_s) begin
                got_q.push_back(m_if.m_data);
                last_q.push_back(m_if.m_last);
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            occ_m      = occ_m + infl_m - int'(pop_s);
            infl_m     = int'(ram_r_en);
            stall_prev = m_if.m_valid & ~m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end
    end

    int c0;

    task automatic clear_logs();
        got_q.delete(); last_q.delete(); addr_q.delete();
        first_en = -1; first_v = -1; last_hs = -1; done_cyc = -1;
        rdy_idx = 0;
    endtask

    // Drive a command so it is sampled on "edge 0"; c0 = cyc of cycle 1.
    task automatic start_cmd(input int b, input int l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(b); len = (ADDR_W+1)'(l);
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != n0) break;
            @(posedge clk);
        end
        #1;
        check("done_seen", 32'(done_cnt), 32'(n0 + 1));
    endtask

    // Expected: addresses (b+i)%16, data 0x100+addr, last only on final word.
    task automatic check_seq(input int b, input int n);
        int a;
        check("word_count", 32'(got_q.size()), 32'(n));
        check("read_count", 32'(addr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = (b + i) % 16;
            check("rd_addr", (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hffff_ffff, 32'(a));
            check("data", (i < got_q.size()) ? got_q[i] : 32'hdead_beef, 32'h100 + 32'(a));
            check("last", (i < last_q.size()) ? 32'(last_q[i]) : 32'hffff_ffff, 32'(i == n - 1));
        end
    endtask

    int n0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h100 + 32'(i);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ren",   32'(ram_r_en), 32'd0);
        check("rst_raddr", 32'(ram_r_addr), 32'd0);
        check("rst_valid", 32'(m_if.m_valid), 32'd0);
        check("rst_data",  m_if.m_data, 32'd0);
        check("rst_last",  32'(m_if.m_last), 32'd0);
        rst = 1'b0;

        // Basic read, no backpressure.
        clear_logs(); n0 = done_cnt;
        start_cmd(4, 5);
        check("busy_run", 32'(busy), 32'd1);
        wait_done(n0);
        check("first_ren_cycle", 32'(first_en - c0), 32'd0);
        check("first_valid_cycle", 32'(first_v - c0), 32'd2);
        check("back_to_back", 32'(last_hs - first_v), 32'd4);
        check("done_after_last", 32'(done_cyc - last_hs), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check_seq(4, 5);

        // Wrap-around.
        clear_logs(); n0 = done_cnt;
        start_cmd(14, 4);
        wait_done(n0);
        check_seq(14, 4);

        // Backpressure.
        rdy_mode = 1;
        clear_logs(); n0 = done_cnt;
        start_cmd(0, 8);
        wait_done(n0);
        check_seq(0, 8);
        rdy_mode = 0;

        // Zero length.
        clear_logs(); n0 = done_cnt;
        start_cmd(3, 0);
        @(negedge clk); #1;
        check("zero_done", 32'(done_cnt), 32'(n0 + 1));
        check("zero_done_cycle", 32'(done_cyc - c0), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_no_read", 32'(addr_q.size()), 32'd0);
        check("zero_no_valid", 32'(first_v), 32'hffff_ffff);
        check("zero_busy", 32'(busy), 32'd0);

        // Start during busy is ignored.
        clear_logs(); n0 = done_cnt;
        start_cmd(2, 3);
        start = 1'b1; base_addr = ADDR_W'(10); len = (ADDR_W+1)'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n0);
        repeat (20) @(posedge clk);
        #1;
        check("ignored_start_cnt", 32'(done_cnt), 32'(n0 + 1));
        check_seq(2, 3);

        // Reset mid-transfer (asynchronous, inside cycle 4).
        clear_logs(); n0 = done_cnt;
        start_cmd(0, 16);
        repeat (3) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_ren",   32'(ram_r_en), 32'd0);
        check("mid_rst_raddr", 32'(ram_r_addr), 32'd0);
        check("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
        check("mid_rst_data",  m_if.m_data, 32'd0);
        check("mid_rst_last",  32'(m_if.m_last), 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cnt), 32'(n0));
        clear_logs(); n0 = done_cnt;
        start_cmd(0, 2);
        wait_done(n0);
        check_seq(0, 2);

        // Full-depth transfer with random ready.
        rdy_mode = 2;
        clear_logs(); n0 = done_cnt;
        start_cmd(9, 16);
        wait_done(n0);
        check_seq(9, 16);
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
